// File: rtl/arbitro_rr_mux_8_1_pkg.sv
// Shared types and helpers for the round-robin 8:1 mux arbiter.
package arbitro_rr_mux_8_1_pkg;

  localparam int N_SRC = 8;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Scans upward from base+1, wrapping 7 -> 0, and returns the first requesting
  // index. When k reaches 8 the 3-bit sum lands back on base, so a lone requester
  // that was just served can be picked again.
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] base);
    logic [2:0] idx;
    logic       found;
    rr_pick = base;
    found   = 1'b0;
    for (int k = 1; k <= N_SRC; k++) begin
      idx = base + 3'(k);
      if (!found && req[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/arbitro_rr_mux_8_1_mux.sv
// Plain 8:1 single-bit multiplexer shared by the eight serial sources.
module multiplex_8_1 (
  input  logic [7:0] d,
  input  logic [2:0] sel,
  output logic       y
);

  // Pure select, no gating; the arbiter decides when the result is meaningful.
  always_comb begin
    y = d[sel];
  end

endmodule

// File: rtl/arbitro_rr_mux_8_1.sv
// Round-robin arbiter that time-slices one 8:1 mux among eight requesters.
module arbitro_rr_mux_8_1
  import arbitro_rr_mux_8_1_pkg::*;
#(
  parameter int SLOT_CYCLES = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic [7:0] d,
  output logic [7:0] grant,
  output logic [2:0] sel,
  output logic       valid,
  output logic       y
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SLOT_CYCLES - 1);

  state_t           state, state_next;
  logic [7:0]       grant_next;
  logic [2:0]       sel_next;
  logic             valid_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic [2:0]       last, last_next;
  logic [2:0]       pick_base;
  logic [2:0]       winner;
  logic             release_now;
  logic             start_grant;
  logic             mux_y;

  // On a release the pointer is updated to sel in the same edge, so the
  // search for a back-to-back grant must already start after sel.
  always_comb begin
    pick_base = (state == GRANT) ? sel : last;
    winner    = rr_pick(req, pick_base);
  end

  // Next-state logic: decide whether the current slot ends and who goes next.
  always_comb begin
    state_next  = state;
    grant_next  = grant;
    sel_next    = sel;
    valid_next  = valid;
    cnt_next    = cnt;
    last_next   = last;
    release_now = 1'b0;
    start_grant = 1'b0;

    case (state)
      IDLE: begin
        grant_next = 8'h00;
        valid_next = 1'b0;
        if (en && |req) begin
          start_grant = 1'b1;
        end
      end
      GRANT: begin
        release_now = !req[sel] || (cnt == CNT_MAX) || !en;
        if (!release_now) begin
          cnt_next = cnt + CNT_W'(1);
        end else begin
          last_next = sel;
          if (en && |req) begin
            start_grant = 1'b1;
          end else begin
            state_next = IDLE;
            grant_next = 8'h00;
            valid_next = 1'b0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = 8'h00;
        valid_next = 1'b0;
      end
    endcase

    if (start_grant) begin
      state_next = GRANT;
      sel_next   = winner;
      grant_next = 8'b1 << winner;
      valid_next = 1'b1;
      cnt_next   = '0;
    end
  end

  // State register; reset clears any grant instantly and rewinds the pointer
  // to 7 so the first search begins at source 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      grant <= 8'h00;
      sel   <= 3'd0;
      valid <= 1'b0;
      cnt   <= '0;
      last  <= 3'd7;
    end else begin
      state <= state_next;
      grant <= grant_next;
      sel   <= sel_next;
      valid <= valid_next;
      cnt   <= cnt_next;
      last  <= last_next;
    end
  end

  multiplex_8_1 u_mux (
    .d  (d),
    .sel(sel),
    .y  (mux_y)
  );

  // Data is not registered: y follows d[sel] within the cycle while granted.
  always_comb begin
    y = valid & mux_y;
  end

endmodule
